uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single UART transmitter between several byte-stream sources (watch time reporter, ultrasonic and DHT11 sensor reporters). Each requester presents a byte stream with valid/ready/last. The arbiter grants one requester for a whole packet and feeds its bytes one at a time to the transmitter via a start/done handshake. It releases the grant on the last byte or on a stall timeout, and sits between the sensor/watch formatters and `uart_tx`.

---
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter that shares a single UART
// transmitter between several valid/ready/last byte-stream sources. A
// requester keeps its grant for a whole packet. The grant is released on the
// last byte, or when the requester stalls mid-packet for too long.
module uart_tx_arbiter #(
    parameter int NREQ         = 3,
    parameter int IDLE_TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [8*NREQ-1:0] i_req_data,
    input  logic [NREQ-1:0]   i_req_last,
    output logic [NREQ-1:0]   o_req_ready,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy,
    input  logic              i_tx_done,
    output logic              o_abort,
    output logic              o_busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(IDLE_TIMEOUT);
    localparam logic [CW-1:0] TO_MAX   = CW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        START,
        WAIT_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [IW-1:0]   grant_idx_reg, grant_idx_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [7:0]      data_reg, data_next;
    logic            last_reg, last_next;
    logic [CW-1:0]   count_reg, count_next;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [NREQ-1:0] win_onehot;
    logic [7:0]      byte_masked [NREQ];
    logic [7:0]      sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic            in_wait_byte;
    logic            handshake;

    assign in_wait_byte = (state_reg == WAIT_BYTE);
    assign sel_valid    = |(i_req_valid & grant_reg);
    assign sel_last     = |(i_req_last & grant_reg);
    assign handshake    = in_wait_byte & sel_valid & ~i_tx_busy;

    // Per-requester slices: masked byte lanes, one-hot winner decode, ready.
    // Only the granted requester is ever readied.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign byte_masked[gi] = i_req_data[8*gi +: 8] & {8{grant_reg[gi]}};
            assign win_onehot[gi]  = (win_idx == IW'(gi));
            assign o_req_ready[gi] = in_wait_byte & grant_reg[gi] & i_req_valid[gi] & ~i_tx_busy;
        end
    endgenerate

    // Byte of the granted requester (grant is one-hot, so OR-merge the lanes).
    always_comb begin
        sel_data = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            sel_data = sel_data | byte_masked[k];
        end
    end

    // Round-robin search: first valid index after ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = ptr_reg;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDX_LAST) ? '0 : cand + IW'(1);
            if (!win_found && i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State and datapath registers; reset drops any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            ptr_reg       <= IDX_LAST;
            data_reg      <= 8'h00;
            last_reg      <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            grant_idx_reg <= grant_idx_next;
            ptr_reg       <= ptr_next;
            data_reg      <= data_next;
            last_reg      <= last_next;
            count_reg     <= count_next;
        end
    end

    // Next-state logic and the start/abort pulses.
    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        grant_idx_next = grant_idx_reg;
        ptr_next       = ptr_reg;
        data_next      = data_reg;
        last_next      = last_reg;
        count_next     = count_reg;
        o_tx_start     = 1'b0;
        o_abort        = 1'b0;

        case (state_reg)
            IDLE: begin
                grant_next = '0;
                count_next = '0;
                if (win_found) begin
                    grant_next     = win_onehot;
                    grant_idx_next = win_idx;
                    state_next     = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (handshake) begin
                    data_next  = sel_data;
                    last_next  = sel_last;
                    count_next = '0;
                    state_next = START;
                end else if (!sel_valid) begin
                    // A stall only counts while the granted source is silent;
                    // transmitter backpressure never advances the timeout.
                    if (count_reg == TO_MAX) begin
                        o_abort    = 1'b1;
                        ptr_next   = grant_idx_reg;
                        grant_next = '0;
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            START: begin
                o_tx_start = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    count_next = '0;
                    if (last_reg) begin
                        ptr_next   = grant_idx_reg;
                        grant_next = '0;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_BYTE;
                    end
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign o_grant   = grant_reg;
    assign o_tx_data = data_reg;
    assign o_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: behavioural requester queues and a simple
// uart_tx model. Expected transmitted bytes are queued in a scoreboard and
// compared at each tx_start.
module tb_uart_tx_arbiter;

    localparam int NREQ   = 3;
    localparam int TO     = 16;
    localparam int TX_LEN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   i_req_valid;
    logic [8*NREQ-1:0] i_req_data;
    logic [NREQ-1:0]   i_req_last;
    logic [NREQ-1:0]   o_req_ready;
    logic [NREQ-1:0]   o_grant;
    logic              o_tx_start;
    logic [7:0]        o_tx_data;
    logic              i_tx_busy;
    logic              i_tx_done;
    logic              o_abort;
    logic              o_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ        (NREQ),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_valid(i_req_valid),
        .i_req_data (i_req_data),
        .i_req_last (i_req_last),
        .o_req_ready(o_req_ready),
        .o_grant    (o_grant),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_busy  (i_tx_busy),
        .i_tx_done  (i_tx_done),
        .o_abort    (o_abort),
        .o_busy     (o_busy)
    );

    typedef struct packed {logic [7:0] d; logic l;} rbyte_t;
    typedef struct packed {logic [7:0] d; logic [2:0] g; logic l;} sb_t;
    typedef struct {logic [2:0] mask; logic [2:0] exp_grant;} vec_t;

    rbyte_t rq [NREQ][$];
    sb_t    sb [$];
    int     checks = 0;
    int     errors = 0;
    int     tx_rem = 0;
    logic   force_busy = 1'b0;
    logic   force_done = 1'b0;
    logic   done_last_prev = 1'b0;
    sb_t    inflight = '0;
    logic [2:0] s_ready, s_grant;
    logic   s_start, s_abort, s_busy, s_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push_req(input int k, input logic [7:0] bd, input logic bl);
        rq[k].push_back('{d: bd, l: bl});
    endtask

    task automatic expect_tx(input logic [7:0] bd, input logic [2:0] bg, input logic bl);
        sb.push_back('{d: bd, g: bg, l: bl});
    endtask

    task automatic clear_models();
        for (int k = 0; k < NREQ; k++) rq[k].delete();
        sb.delete();
        tx_rem         = 0;
        force_busy     = 1'b0;
        force_done     = 1'b0;
        done_last_prev = 1'b0;
        inflight       = '0;
        i_req_valid    = '0;
        i_req_data     = '0;
        i_req_last     = '0;
        i_tx_busy      = 1'b0;
        i_tx_done      = 1'b0;
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            if (rq[k].size() > 0) begin
                i_req_valid[k]       = 1'b1;
                i_req_data[8*k +: 8] = rq[k][0].d;
                i_req_last[k]        = rq[k][0].l;
            end else begin
                i_req_valid[k]       = 1'b0;
                i_req_data[8*k +: 8] = 8'h00;
                i_req_last[k]        = 1'b0;
            end
        end
        i_tx_busy = force_busy || (tx_rem > 0);
        i_tx_done = force_done || (tx_rem == 1);
    endtask

    // One clock cycle: drive, sample mid-cycle, check, then advance the models.
    task automatic step();
        sb_t e;
        drive();
        #2;
        s_ready = o_req_ready;
        s_grant = o_grant;
        s_start = o_tx_start;
        s_abort = o_abort;
        s_busy  = o_busy;
        s_done  = (tx_rem == 1);
        chk("ready_onehot", 32'($onehot0(o_req_ready) && ((o_req_ready & ~o_grant) == 3'b000)), 32'd1);
        if (done_last_prev) chk("release", 32'({o_busy, o_grant}), 32'd0);
        if (tx_rem > 0) chk("data_stable", 32'(o_tx_data), 32'(inflight.d));
        if (o_tx_start) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow act=start data %h exp=no start", o_tx_data);
            end else begin
                e = sb.pop_front();
                $display("tx byte %h grant %b last %b", o_tx_data, o_grant, e.l);
                chk("tx_byte", 32'({o_grant, o_tx_data}), 32'({e.g, e.d}));
                inflight = e;
            end
        end
        @(posedge clk);
        #1;
        done_last_prev = s_done && inflight.l;
        for (int k = 0; k < NREQ; k++) begin
            if (s_ready[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        end
        if (tx_rem > 0) tx_rem--;
        if (s_start) tx_rem = TX_LEN;
    endtask

    task automatic wait_idle(input int budget);
        int   n;
        logic idle;
        n    = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            step();
            n++;
            idle = !s_busy && sb.size() == 0 && tx_rem == 0 &&
                   rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0;
        end
        chk("idle_reached", 32'(idle), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_done && n < budget);
        chk("done_seen", 32'(s_done), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   w;
        int   n;
        vecs[0] = '{3'b111, 3'b001};
        vecs[1] = '{3'b111, 3'b010};
        vecs[2] = '{3'b101, 3'b100};
        vecs[3] = '{3'b110, 3'b010};
        vecs[4] = '{3'b001, 3'b001};
        vecs[5] = '{3'b101, 3'b100};
        vecs[6] = '{3'b100, 3'b100};
        vecs[7] = '{3'b011, 3'b001};

        // Reset values
        rst = 1'b1;
        clear_models();
        #3;
        chk("reset_outputs", 32'({o_grant, o_req_ready, o_tx_start, o_tx_data, o_abort, o_busy}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Arbitration table: one-byte packets, losers withdrawn after the grant
        for (int r = 0; r < 8; r++) begin
            w = vecs[r].exp_grant[0] ? 0 : (vecs[r].exp_grant[1] ? 1 : 2);
            for (int k = 0; k < NREQ; k++)
                if (vecs[r].mask[k]) push_req(k, 8'(16 * r + k), 1'b1);
            expect_tx(8'(16 * r + w), vecs[r].exp_grant, 1'b1);
            step();
            step();
            chk("table_grant", 32'(s_grant), 32'(vecs[r].exp_grant));
            for (int k = 0; k < NREQ; k++)
                if (!vecs[r].exp_grant[k]) rq[k].delete();
            wait_idle(40);
        end

        // Single two-byte packet from requester 1
        do_reset();
        push_req(1, 8'h41, 1'b0);
        push_req(1, 8'h42, 1'b1);
        expect_tx(8'h41, 3'b010, 1'b0);
        expect_tx(8'h42, 3'b010, 1'b1);
        step();
        chk("sp_idle_grant", 32'(s_grant), 32'd0);
        step();
        chk("sp_grant_ready", 32'({s_grant, s_ready}), 32'({3'b010, 3'b010}));
        step();
        chk("sp_start", 32'(s_start), 32'd1);
        wait_idle(60);

        // Round robin with all requesters holding 2-byte packets
        do_reset();
        push_req(0, 8'hA0, 1'b0); push_req(0, 8'hA1, 1'b1);
        push_req(0, 8'hA2, 1'b0); push_req(0, 8'hA3, 1'b1);
        push_req(1, 8'hB0, 1'b0); push_req(1, 8'hB1, 1'b1);
        push_req(2, 8'hC0, 1'b0); push_req(2, 8'hC1, 1'b1);
        expect_tx(8'hA0, 3'b001, 1'b0); expect_tx(8'hA1, 3'b001, 1'b1);
        expect_tx(8'hB0, 3'b010, 1'b0); expect_tx(8'hB1, 3'b010, 1'b1);
        expect_tx(8'hC0, 3'b100, 1'b0); expect_tx(8'hC1, 3'b100, 1'b1);
        expect_tx(8'hA2, 3'b001, 1'b0); expect_tx(8'hA3, 3'b001, 1'b1);
        wait_idle(200);

        // Busy backpressure longer than the timeout, valid held high
        do_reset();
        force_busy = 1'b1;
        push_req(0, 8'h61, 1'b0);
        push_req(0, 8'h62, 1'b1);
        expect_tx(8'h61, 3'b001, 1'b0);
        expect_tx(8'h62, 3'b001, 1'b1);
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_hold", 32'({s_ready, s_start, s_abort, s_grant}), 32'({3'b000, 1'b0, 1'b0, 3'b001}));
        end
        force_busy = 1'b0;
        step();
        chk("bp_release", 32'(s_ready), 32'(3'b001));
        wait_idle(60);

        // Stall timeout: requester 2 sends one non-last byte then goes silent
        do_reset();
        push_req(2, 8'hC5, 1'b0);
        expect_tx(8'hC5, 3'b100, 1'b0);
        wait_done(30);
        for (int k = 0; k < 18; k++) begin
            if (k == 3) begin
                push_req(0, 8'hD1, 1'b1);
                expect_tx(8'hD1, 3'b001, 1'b1);
            end
            force_done = (k == 5);
            step();
            force_done = 1'b0;
            if (k < 15)
                chk("to_wait", 32'({s_abort, s_grant, s_ready}), 32'({1'b0, 3'b100, 3'b000}));
            else if (k == 15)
                chk("to_abort", 32'({s_abort, s_grant, s_ready}), 32'({1'b1, 3'b100, 3'b000}));
            else if (k == 16)
                chk("to_idle", 32'({s_abort, s_grant, s_ready}), 32'({1'b0, 3'b000, 3'b000}));
            else
                chk("to_regrant", 32'({s_abort, s_grant, s_ready}), 32'({1'b0, 3'b001, 3'b001}));
        end
        wait_idle(40);

        // Back-to-back one-byte packets from requester 0
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push_req(0, 8'(8'h90 + p), 1'b1);
            expect_tx(8'(8'h90 + p), 3'b001, 1'b1);
        end
        for (int p = 0; p < 4; p++) begin
            wait_done(30);
            step();
            chk("b2b_gap", 32'(s_grant), 32'd0);
            step();
            chk("b2b_regrant", 32'(s_grant), (p < 3) ? 32'(3'b001) : 32'd0);
        end
        wait_idle(20);

        // Asynchronous reset during WAIT_DONE
        do_reset();
        push_req(1, 8'h71, 1'b0);
        push_req(1, 8'h72, 1'b1);
        expect_tx(8'h71, 3'b010, 1'b0);
        expect_tx(8'h72, 3'b010, 1'b1);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_start && n < 10);
        chk("mr_started", 32'(s_start), 32'd1);
        step();
        step();
        rst = 1'b1;
        #2;
        chk("async_reset", 32'({o_grant, o_req_ready, o_tx_start, o_tx_data, o_abort, o_busy}), 32'd0);
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_quiet", 32'({s_start, s_grant, s_busy}), 32'd0);
        end
        push_req(0, 8'h80, 1'b1);
        push_req(1, 8'h81, 1'b1);
        expect_tx(8'h80, 3'b001, 1'b1);
        expect_tx(8'h81, 3'b010, 1'b1);
        step();
        step();
        chk("post_reset_first", 32'(s_grant), 32'(3'b001));
        wait_idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
